// File: rtl/booth_spm.sv
// Sequential radix-2 Booth multiplier fed from a shared switch bus with a Go level handshake.
// Optional BOOTH_UNSIGNED_EN: operands zero-extended and one extra Booth step for unsigned.
module booth_spm #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   SW,
  input  logic           Go,
  output logic [2*N-1:0] Answer,
  output logic           Over
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int unsigned M = N + 1;
`else
  localparam int unsigned M = N;
`endif
  localparam int unsigned CntW = $clog2(M + 1);

  typedef enum logic [2:0] {
    StWaitA,
    StRelA,
    StWaitB,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [M-1:0]      a_q, a_d;
  logic [M:0]        p_q, p_d;
  logic [M-1:0]      q_q, q_d;
  logic              qm1_q, qm1_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]    answer_q, answer_d;
  logic              over_q, over_d;

  logic [M-1:0]      sw_ext;
  logic [M:0]        a_ext;
  logic [M:0]        p_sum;

  // Operand as seen by the datapath: M bits, sign- or zero-extended from the bus.
  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    sw_ext = {1'b0, SW};
`else
    sw_ext = SW;
`endif
  end

  always_comb begin
    a_ext = {a_q[M-1], a_q};
    unique case ({q_q[0], qm1_q})
      2'b01:   p_sum = p_q + a_ext;
      2'b10:   p_sum = p_q - a_ext;
      default: p_sum = p_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    p_d      = p_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    answer_d = answer_q;
    over_d   = over_q;
    unique case (state_q)
      StWaitA: begin
        if (Go) begin
          a_d     = sw_ext;
          state_d = StRelA;
        end
      end
      StRelA: begin
        if (!Go) state_d = StWaitB;
      end
      StWaitB: begin
        if (Go) begin
          q_d     = sw_ext;
          qm1_d   = 1'b0;
          p_d     = '0;
          cnt_d   = CntW'(M);
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          // Add/subtract then arithmetic shift of {P, Q, q_-1} by one.
          p_d   = {p_sum[M], p_sum[M:1]};
          q_d   = {p_sum[0], q_q[M-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q - CntW'(1);
        end else begin
          answer_d = (2*N)'({p_q, q_q});
          over_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (!Go) begin
          over_d  = 1'b0;
          state_d = StWaitA;
        end
      end
      default: begin
        over_d  = 1'b0;
        state_d = StWaitA;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StWaitA;
      a_q      <= '0;
      p_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      answer_q <= '0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      p_q      <= p_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      answer_q <= answer_d;
      over_q   <= over_d;
    end
  end

  assign Answer = answer_q;
  assign Over   = over_q;

endmodule

// File: tb/tb_booth_spm.sv
// Directed self-checking bench for booth_spm; expected products are hand-computed constants.
module tb_booth_spm;

  logic        clk;
  logic        rst;
  logic [7:0]  SW;
  logic        Go;
  logic [15:0] Answer;
  logic        Over;

  int pass_cnt = 0;
  int total    = 0;

`ifdef BOOTH_UNSIGNED_EN
  localparam int Lat = 10;
`else
  localparam int Lat = 9;
`endif

  booth_spm #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .SW     (SW),
    .Go     (Go),
    .Answer (Answer),
    .Over   (Over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enter A then B, then count edges after B capture until Over rises (bounded).
  task automatic mul_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] ans, output int lat);
    @(negedge clk); SW = a; Go = 1'b1;
    @(negedge clk); Go = 1'b0;
    @(negedge clk); SW = b; Go = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (Over) begin
        lat = i;
        break;
      end
    end
    ans = Answer;
  endtask

  task automatic release_go(output logic over_after, output logic [15:0] ans_after);
    @(negedge clk); Go = 1'b0;
    @(posedge clk); #1;
    over_after = Over;
    ans_after  = Answer;
  endtask

  task automatic test_reset;
    total++;
    if (Answer !== 16'h0000) $display("FAIL reset_answer got %h want 0000", Answer);
    else pass_cnt++;
    total++;
    if (Over !== 1'b0) $display("FAIL reset_over got %b want 0", Over);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_first;
    logic [15:0] ans, ans2, exp;
    logic        ov;
    int          lat;
`ifdef BOOTH_UNSIGNED_EN
    exp = 16'hFB06;
`else
    exp = 16'h0006;
`endif
    @(negedge clk); SW = 8'd253; Go = 1'b1;
    @(negedge clk);
    @(negedge clk); Go = 1'b0;
    @(negedge clk); SW = 8'd254; Go = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (Over) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat !== Lat) $display("FAIL first_latency got %0d want %0d", lat, Lat);
    else pass_cnt++;
    total++;
    if (Answer !== exp) $display("FAIL first_answer got %h want %h", Answer, exp);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (Over !== 1'b1 || Answer !== exp)
        $display("FAIL done_hold over %b answer %h want 1 %h", Over, Answer, exp);
      else pass_cnt++;
    end
    release_go(ov, ans2);
    total++;
    if (ov !== 1'b0) $display("FAIL first_over_drop got %b want 0", ov);
    else pass_cnt++;
    total++;
    if (ans2 !== exp) $display("FAIL first_answer_keep got %h want %h", ans2, exp);
    else pass_cnt++;
    ans = ans2;
  endtask

  task automatic test_vectors;
    logic [7:0]  va [6];
    logic [7:0]  vb [6];
    logic [15:0] ve [6];
    logic [15:0] ans, ans2;
    logic        ov;
    int          lat;
    va[0] = 8'h03; vb[0] = 8'h05; ve[0] = 16'h000F;
    va[1] = 8'h7F; vb[1] = 8'h80;
    va[2] = 8'h80; vb[2] = 8'h80; ve[2] = 16'h4000;
    va[3] = 8'h00; vb[3] = 8'hA5; ve[3] = 16'h0000;
    va[4] = 8'hFF; vb[4] = 8'h01;
    va[5] = 8'hFF; vb[5] = 8'hFF;
`ifdef BOOTH_UNSIGNED_EN
    ve[1] = 16'h3F80; ve[4] = 16'h00FF; ve[5] = 16'hFE01;
`else
    ve[1] = 16'hC080; ve[4] = 16'hFFFF; ve[5] = 16'h0001;
`endif
    for (int k = 0; k < 6; k++) begin
      mul_op(va[k], vb[k], ans, lat);
      total++;
      if (lat !== Lat) $display("FAIL vec%0d_latency got %0d want %0d", k, lat, Lat);
      else pass_cnt++;
      total++;
      if (ans !== ve[k]) $display("FAIL vec%0d_answer got %h want %h", k, ans, ve[k]);
      else pass_cnt++;
      release_go(ov, ans2);
      total++;
      if (ov !== 1'b0) $display("FAIL vec%0d_over_drop got %b want 0", k, ov);
      else pass_cnt++;
    end
  endtask

  task automatic test_go_hold;
    logic        ov;
    logic [15:0] ans2;
    int          lat;
    @(negedge clk); SW = 8'h11; Go = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      SW = (i % 2 == 0) ? 8'h22 : 8'h33;
      total++;
      if (Over !== 1'b0) $display("FAIL go_hold_over cycle %0d got %b want 0", i, Over);
      else pass_cnt++;
    end
    Go = 1'b0;
    @(negedge clk); SW = 8'h02; Go = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); SW = ~SW; Go = ~Go;
      @(posedge clk); #1;
      if (Over) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat !== Lat) $display("FAIL go_hold_latency got %0d want %0d", lat, Lat);
    else pass_cnt++;
    total++;
    if (Answer !== 16'h0022) $display("FAIL go_hold_answer got %h want 0022", Answer);
    else pass_cnt++;
    release_go(ov, ans2);
    total++;
    if (ov !== 1'b0) $display("FAIL go_hold_over_drop got %b want 0", ov);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] ans, exp;
    int          lat;
`ifdef BOOTH_UNSIGNED_EN
    exp = 16'h06D6;
`else
    exp = 16'hFFD6;
`endif
    @(negedge clk); SW = 8'h05; Go = 1'b1;
    @(negedge clk); Go = 1'b0;
    @(negedge clk); SW = 8'h09; Go = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; Go = 1'b0;
    #1;
    total++;
    if (Answer !== 16'h0000 || Over !== 1'b0)
      $display("FAIL mid_reset got answer %h over %b want 0000 0", Answer, Over);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (Answer !== 16'h0000 || Over !== 1'b0)
      $display("FAIL mid_reset_hold got answer %h over %b want 0000 0", Answer, Over);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    mul_op(8'h07, 8'hFA, ans, lat);
    total++;
    if (lat !== Lat) $display("FAIL after_reset_latency got %0d want %0d", lat, Lat);
    else pass_cnt++;
    total++;
    if (ans !== exp) $display("FAIL after_reset_answer got %h want %h", ans, exp);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    SW  = 8'h00;
    Go  = 1'b0;
    #12;
    test_reset;
    test_first;
    test_vectors;
    test_go_hold;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
